// File: rtl/wave_display_mc_pkg.sv
// Shared constants and types for the multi-channel waveform pixel generator.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional grid overlay is selected with WAVE_GRID_EN.
package wave_display_mc_pkg;

  localparam int COLOR_W = 8;
  localparam logic [COLOR_W-1:0] GREY = 8'h40;
  localparam int X_START_DEF = 268;
  localparam int X_END_DEF   = 767;

  typedef enum logic {IDLE, PENDING} bank_state_t;

endpackage

// File: rtl/wave_display_mc_chan_cmp.sv
// One trace channel: previous-sample register and min/max range test against the row.
// Latency: combinational hit from cur/y_s; prev register updates at the clock edge.
// Backpressure: none, one sample per clock.
module wave_chan_cmp #(
  parameter int SAMPLE_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                in_region,
  input  logic                first,
  input  logic                load,
  input  logic [SAMPLE_W-1:0] y_s,
  input  logic [SAMPLE_W-1:0] cur,
  output logic                hit
);

  logic [SAMPLE_W-1:0] prev_q;
  logic [SAMPLE_W-1:0] last_q;
  logic [SAMPLE_W-1:0] prev_eff;
  logic [SAMPLE_W-1:0] lo;
  logic [SAMPLE_W-1:0] hi;

  // Segment endpoints: line start collapses to the current sample, a new column
  // takes the sample seen on the previous cycle (the previous column's word).
  always_comb begin
    prev_eff = prev_q;
    if (first)
      prev_eff = cur;
    else if (load)
      prev_eff = last_q;
    lo  = (prev_eff < cur) ? prev_eff : cur;
    hi  = (prev_eff < cur) ? cur : prev_eff;
    hit = enable && in_region && (y_s >= lo) && (y_s <= hi);
  end

  // Track the last read word every cycle; latch the segment start on column change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
      last_q <= '0;
    end else begin
      last_q <= cur;
      if (load)
        prev_q <= prev_eff;
    end
  end

endmodule

// File: rtl/wave_display_mc.sv
// Multi-channel oscilloscope pixel generator with frame-synchronous bank swap.
// Latency: 2 clk from x/y/valid to r/g/b/valid_pixel; read_address is combinational.
// Backpressure: none, one pixel per clock. Grid overlay compiled in with WAVE_GRID_EN.
module wave_display_mc
  import wave_display_mc_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int SAMPLE_W  = 8,
  parameter int ADDR_W    = 9,
  parameter int X_START   = X_START_DEF,
  parameter int X_END     = X_END_DEF,
  parameter int COL_SHIFT = 1,
  parameter int Y_SHIFT   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [10:0]                x,
  input  logic [9:0]                 y,
  input  logic                       valid,
  input  logic                       frame_start,
  input  logic                       swap_req,
  output logic                       swap_ack,
  input  logic [NUM_CH-1:0]          ch_enable,
  input  logic [24*NUM_CH-1:0]       ch_color,
  output logic [ADDR_W-1:0]          read_address,
  input  logic [NUM_CH*SAMPLE_W-1:0] read_data,
  output logic                       valid_pixel,
  output logic [COLOR_W-1:0]         r,
  output logic [COLOR_W-1:0]         g,
  output logic [COLOR_W-1:0]         b
);

  localparam int COL_W = ADDR_W - 1;

  bank_state_t         state, state_n;
  logic                bank, bank_n, ack_n;
  logic [10:0]         x_off;
  logic                in_region;
  logic [COL_W-1:0]    col;
  logic                in_region_q, first_q;
  logic [SAMPLE_W-1:0] y_q;
  logic [COL_W-1:0]    col_q, col_d;
  logic                load;
  logic [NUM_CH-1:0]   hit;
  logic                pix_vld;
  logic [23:0]         pix_col;

  assign x_off        = x - 11'(X_START);
  assign in_region    = valid && (x >= 11'(X_START)) && (x <= 11'(X_END));
  assign col          = in_region ? COL_W'(x_off >> COL_SHIFT) : '0;
  assign read_address = {bank, col};
  assign load         = first_q || (col_q != col_d);

  // S0: register raster-derived controls alongside the RAM read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_region_q <= 1'b0;
      first_q     <= 1'b0;
      y_q         <= '0;
      col_q       <= '0;
      col_d       <= '0;
    end else begin
      in_region_q <= in_region;
      first_q     <= in_region && (x == 11'(X_START));
      y_q         <= SAMPLE_W'(y >> Y_SHIFT);
      col_q       <= col;
      col_d       <= col_q;
    end
  end

`ifdef WAVE_GRID_EN
  logic grid_q;

  // S0: grid lines every 64 pixels from the region origin and every 64 rows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      grid_q <= 1'b0;
    else
      grid_q <= in_region && ((x_off[5:0] == 6'd0) || (y[5:0] == 6'd0));
  end
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    wave_chan_cmp #(.SAMPLE_W(SAMPLE_W)) u_cmp (
      .clk       (clk),
      .reset     (reset),
      .enable    (ch_enable[c]),
      .in_region (in_region_q),
      .first     (first_q),
      .load      (load),
      .y_s       (y_q),
      .cur       (read_data[c*SAMPLE_W +: SAMPLE_W]),
      .hit       (hit[c])
    );
  end

  // Priority select: scanning downward lets the lowest-index hitting channel win.
  always_comb begin
    pix_vld = 1'b0;
    pix_col = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (hit[c]) begin
        pix_vld = 1'b1;
        pix_col = ch_color[24*c +: 24];
      end
    end
`ifdef WAVE_GRID_EN
    if (!pix_vld && grid_q) begin
      pix_vld = 1'b1;
      pix_col = {GREY, GREY, GREY};
    end
`endif
  end

  // S1: register the pixel outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_pixel <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
    end else begin
      valid_pixel <= pix_vld;
      r           <= pix_col[23:16];
      g           <= pix_col[15:8];
      b           <= pix_col[7:0];
    end
  end

  // Bank FSM next state: a swap request is honoured at the next frame start.
  always_comb begin
    state_n = state;
    bank_n  = bank;
    ack_n   = 1'b0;
    case (state)
      IDLE: begin
        if (swap_req && frame_start) begin
          bank_n = ~bank;
          ack_n  = 1'b1;
        end else if (swap_req) begin
          state_n = PENDING;
        end
      end
      PENDING: begin
        if (frame_start) begin
          bank_n  = ~bank;
          ack_n   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Bank FSM state, bank select and one-cycle acknowledge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bank     <= 1'b0;
      swap_ack <= 1'b0;
    end else begin
      state    <= state_n;
      bank     <= bank_n;
      swap_ack <= ack_n;
    end
  end

endmodule

// File: tb/tb_wave_display_mc.sv
// Self-checking bench for wave_display_mc with a scoreboard of expected pixels.
// Latency: expects outputs two register stages after each driven raster position.
// Backpressure: none; the RAM model answers every address one clock later.
module tb_wave_display_mc;

  localparam int XS = 268;
  localparam int XE = 767;
  localparam logic [23:0] C0 = 24'h12A0F3;
  localparam logic [23:0] C1 = 24'h5C3E81;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] x = '0;
  logic [9:0]  y = '0;
  logic        valid = 1'b0;
  logic        frame_start = 1'b0;
  logic        swap_req = 1'b0;
  logic        swap_ack;
  logic [1:0]  ch_enable = 2'b01;
  logic [47:0] ch_color = {C1, C0};
  logic [8:0]  read_address;
  logic [15:0] read_data = '0;
  logic        valid_pixel;
  logic [7:0]  r, g, b;

  logic [15:0] mem [0:511];
  logic [24:0] sb[$];
  int          exp_bank = 0;
  int          ack_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  wave_display_mc dut (
    .clk          (clk),
    .reset        (reset),
    .x            (x),
    .y            (y),
    .valid        (valid),
    .frame_start  (frame_start),
    .swap_req     (swap_req),
    .swap_ack     (swap_ack),
    .ch_enable    (ch_enable),
    .ch_color     (ch_color),
    .read_address (read_address),
    .read_data    (read_data),
    .valid_pixel  (valid_pixel),
    .r            (r),
    .g            (g),
    .b            (b)
  );

  always #5 clk = ~clk;

  // Synchronous sample RAM, one cycle read latency.
  always @(posedge clk) read_data <= mem[read_address];

  task automatic fill(input int bk, input logic [7:0] s0, input logic [7:0] s1);
    for (int a = 0; a < 256; a++) mem[bk*256 + a] = {s1, s0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (swap_ack === 1'b1) ack_cnt++;
  endtask

  // Reference pixel: segment from the previous column's sample (or itself on column 0).
  function automatic logic [24:0] model_pix(input int xx, input int yy);
    logic [24:0] res;
    logic [15:0] wc, wp;
    logic [7:0]  cur, prv, lo, hi, ys;
    int          col;
    res = '0;
    if (xx < XS || xx > XE) return res;
    col = (xx - XS) >> 1;
    ys  = 8'((yy >> 1) & 255);
    wc  = mem[exp_bank*256 + col];
    wp  = (col == 0) ? wc : mem[exp_bank*256 + col - 1];
    for (int c = 1; c >= 0; c--) begin
      cur = wc[c*8 +: 8];
      prv = wp[c*8 +: 8];
      lo  = (cur < prv) ? cur : prv;
      hi  = (cur < prv) ? prv : cur;
      if (ch_enable[c] && ys >= lo && ys <= hi) res = {1'b1, ch_color[c*24 +: 24]};
    end
`ifdef WAVE_GRID_EN
    if (!res[24] && ((((xx - XS) & 63) == 0) || ((yy & 63) == 0))) res = {1'b1, 24'h404040};
`endif
    return res;
  endfunction

  // Drive one raster position, queue its expected pixel, return the output after the edge.
  task automatic px(input int xx, input int yy, input logic vld, output logic [24:0] o);
    x     = 11'(xx);
    y     = 10'(yy);
    valid = vld;
    sb.push_back(vld ? model_pix(xx, yy) : 25'd0);
    tick();
    o = {valid_pixel, r, g, b};
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({valid_pixel, r, g, b} !== 25'd0) begin
      errors++; $display("FAIL reset_pix got %h want 0", {valid_pixel, r, g, b});
    end
    checks++;
    if (swap_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", swap_ack); end
    checks++;
    if (read_address !== 9'd0) begin errors++; $display("FAIL reset_addr got %h want 0", read_address); end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    tick();
    checks++;
    if ({valid_pixel, r, g, b} !== 25'd0) begin
      errors++; $display("FAIL post_reset_pix got %h want 0", {valid_pixel, r, g, b});
    end
  endtask

  // Sweep a range of x on one row; the first output belongs to the previous drive, so pop one late.
  task automatic run_line(input int xa, input int xb, input int yy, input string nm);
    logic [24:0] o, e;
    sb.delete();
    for (int xx = xa; xx <= xb + 1; xx++) begin
      if (xx <= xb) px(xx, yy, 1'b1, o);
      else px(0, yy, 1'b0, o);
      if (xx > xa) begin
        e = sb.pop_front();
        checks++;
        if (o !== e) begin
          errors++; $display("FAIL %s x=%0d y=%0d got %h want %h", nm, xx - 1, yy, o, e);
        end
      end
    end
    sb.delete();
  endtask

  task automatic test_flat();
    fill(0, 8'h40, 8'h00);
    ch_enable = 2'b01;
    run_line(266, 770, 128, "flat_y128");
    run_line(266, 770, 130, "flat_y130");
  endtask

  task automatic test_rising();
    fill(0, 8'd20, 8'h00);
    mem[0] = {8'h00, 8'd10};
    run_line(266, 275, 30, "rising_y30");
    run_line(266, 275, 44, "rising_y44");
  endtask

  task automatic test_line_start();
    fill(0, 8'h10, 8'h00);
    mem[249] = {8'h00, 8'hF0};
    run_line(266, 770, 64, "linestart_a");
    run_line(266, 272, 64, "linestart_b");
  endtask

  task automatic test_overlap();
    fill(0, 8'h20, 8'h20);
    ch_enable = 2'b11;
    run_line(266, 275, 64, "overlap_en11");
    ch_enable = 2'b10;
    run_line(266, 275, 64, "overlap_en10");
    ch_enable = 2'b01;
  endtask

  task automatic test_bank_swap();
    ack_cnt = 0;
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    checks++;
    if (read_address[8] !== 1'b0) begin errors++; $display("FAIL pend_bank got %b want 0", read_address[8]); end
    tick(); tick();
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    tick();
    checks++;
    if (ack_cnt !== 0) begin errors++; $display("FAIL early_ack got %0d want 0", ack_cnt); end
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    checks++;
    if (read_address[8] !== 1'b1) begin errors++; $display("FAIL swap_bank got %b want 1", read_address[8]); end
    checks++;
    if (swap_ack !== 1'b1) begin errors++; $display("FAIL swap_ack_pulse got %b want 1", swap_ack); end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (ack_cnt !== 1) begin errors++; $display("FAIL ack_count got %0d want 1", ack_cnt); end
    exp_bank = 1;
    fill(1, 8'h30, 8'h00);
    run_line(266, 300, 96, "bank1_draw");
    ack_cnt = 0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    tick(); tick();
    checks++;
    if (read_address[8] !== 1'b1 || ack_cnt !== 0) begin
      errors++; $display("FAIL idle_frame got bank=%b acks=%0d want bank=1 acks=0", read_address[8], ack_cnt);
    end
    swap_req = 1'b1; frame_start = 1'b1; tick(); swap_req = 1'b0; frame_start = 1'b0;
    checks++;
    if (read_address[8] !== 1'b0 || swap_ack !== 1'b1) begin
      errors++; $display("FAIL same_cycle got bank=%b ack=%b want bank=0 ack=1", read_address[8], swap_ack);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (ack_cnt !== 1) begin errors++; $display("FAIL same_cycle_acks got %0d want 1", ack_cnt); end
    exp_bank = 0;
  endtask

  task automatic test_reset_mid();
    logic [24:0] o;
    fill(0, 8'h40, 8'h00);
    ch_enable = 2'b01;
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    run_line(266, 399, 128, "pre_reset");
    x = 11'd400; y = 10'd128; valid = 1'b1; tick();
    x = 11'd401; tick();
    o = {valid_pixel, r, g, b};
    checks++;
    if (o !== {1'b1, C0}) begin errors++; $display("FAIL x400_drawn got %h want %h", o, {1'b1, C0}); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({valid_pixel, r, g, b} !== 25'd0) begin
      errors++; $display("FAIL reset_mid_pix got %h want 0", {valid_pixel, r, g, b});
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    valid = 1'b0; x = '0;
    ack_cnt = 0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (read_address[8] !== 1'b0 || ack_cnt !== 0) begin
      errors++; $display("FAIL reset_drop got bank=%b acks=%0d want bank=0 acks=0", read_address[8], ack_cnt);
    end
  endtask

  initial begin
    for (int a = 0; a < 512; a++) mem[a] = '0;
    test_reset();
    test_flat();
    test_rising();
    test_line_start();
    test_overlap();
    test_bank_swap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
